// File: rtl/qnigma_key_decoder.sv
// Streaming key loader: assembles KEY_BYTES from IN_BYTES beats with
// LE / X25519-clamp / BE decoding and holds the key until consumed.
module qnigma_key_decoder #(
  parameter int KEY_BYTES = 32,
  parameter int IN_BYTES  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   abort,
  input  logic                   in_val,
  input  logic [8*IN_BYTES-1:0]  in_dat,
  input  logic                   in_last,
  output logic                   in_rdy,
  output logic [8*KEY_BYTES-1:0] out_key,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic                   out_err
);

  localparam int NB = KEY_BYTES / IN_BYTES;
  localparam int CW = $clog2(NB + 1);
  localparam int SW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d, mode_cur;
  logic [7:0]    key_q [KEY_BYTES];
  logic [7:0]    key_d [KEY_BYTES];
  logic          val_q, val_d;
  logic          err_q, err_d;
  logic          rdy_q, rdy_d;
  logic          xfer, last_exp;
  logic [SW-1:0] s_idx, p_idx;
  logic [7:0]    byte_v;

  assign xfer     = in_val & rdy_q;
  assign last_exp = (cnt_q == CW'(NB - 1));

  // mode is only sampled on the first beat; reserved maps to raw LE
  always_comb begin
    mode_cur = mode_q;
    if (state_q == S_IDLE) begin
      mode_cur = (mode == 2'd3) ? 2'd0 : mode;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    key_d   = key_q;
    val_d   = val_q;
    err_d   = 1'b0;
    s_idx   = '0;
    p_idx   = '0;
    byte_v  = '0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      val_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_LOAD: begin
          if (xfer) begin
            if (in_last != last_exp) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              mode_d = mode_cur;
              for (int j = 0; j < IN_BYTES; j++) begin
                s_idx  = SW'(int'(cnt_q) * IN_BYTES + j);
                byte_v = in_dat[8*j +: 8];
                if (mode_cur == 2'd1) begin
                  if (s_idx == '0) begin
                    byte_v = byte_v & 8'hF8;
                  end
                  if (s_idx == SW'(KEY_BYTES - 1)) begin
                    byte_v = (byte_v & 8'h7F) | 8'h40;
                  end
                end
                p_idx = (mode_cur == 2'd2) ?
                        SW'(KEY_BYTES - 1) - s_idx : s_idx;
                key_d[p_idx] = byte_v;
              end
              if (last_exp) begin
                state_d = S_DONE;
                cnt_d   = '0;
                val_d   = 1'b1;
              end else begin
                state_d = S_LOAD;
                cnt_d   = cnt_q + CW'(1);
              end
            end
          end
        end
        S_DONE: begin
          if (out_rdy) begin
            state_d = S_IDLE;
            val_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          val_d   = 1'b0;
        end
      endcase
    end
    rdy_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      key_q   <= '{default: 8'h00};
      val_q   <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      val_q   <= val_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    out_key = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      out_key[8*k +: 8] = key_q[k];
    end
  end

  assign in_rdy  = rdy_q;
  assign out_val = val_q;
  assign out_err = err_q;

endmodule

// File: tb/tb_qnigma_key_decoder.sv
// Bench for qnigma_key_decoder: byte-wide and 4-byte-wide instances,
// scoreboard of expected keys compared whenever out_val is high.
module tb_qnigma_key_decoder;

  typedef logic [7:0] key_t [32];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   mode;
  logic         abort, in_val, in_last, in_rdy;
  logic [7:0]   in_dat;
  logic [255:0] out_key;
  logic         out_val, out_rdy, out_err;

  logic [1:0]   mode4;
  logic         abort4, in_val4, in_last4, in_rdy4;
  logic [31:0]  in_dat4;
  logic [255:0] out_key4;
  logic         out_val4, out_rdy4, out_err4;

  int checks = 0;
  int errors = 0;
  int nerr1  = 0;
  int nerr4  = 0;
  bit rdy4_rand = 1'b0;
  logic [255:0] sb1 [$];
  logic [255:0] sb4 [$];

  qnigma_key_decoder #(.KEY_BYTES(32), .IN_BYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .mode(mode), .abort(abort),
    .in_val(in_val), .in_dat(in_dat), .in_last(in_last),
    .in_rdy(in_rdy), .out_key(out_key), .out_val(out_val),
    .out_rdy(out_rdy), .out_err(out_err)
  );

  qnigma_key_decoder #(.KEY_BYTES(32), .IN_BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .abort(abort4),
    .in_val(in_val4), .in_dat(in_dat4), .in_last(in_last4),
    .in_rdy(in_rdy4), .out_key(out_key4), .out_val(out_val4),
    .out_rdy(out_rdy4), .out_err(out_err4)
  );

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // stream byte 0 lands at the LSB for LE, at the MSB for BE
  function automatic logic [255:0] model(input key_t kb, input logic [1:0] m);
    logic [255:0] r;
    logic [7:0]   b;
    r = '0;
    for (int s = 0; s < 32; s++) begin
      b = kb[s];
      if (m == 2'd1 && s == 0) b = {b[7:3], 3'b000};
      if (m == 2'd1 && s == 31) b = {2'b01, b[5:0]};
      if (m == 2'd2) r = {r[247:0], b};
      else r[8*s +: 8] = b;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_err) nerr1++;
      if (out_val) begin
        if (sb1.size() == 0) check("val1_unexp", out_val, 0);
        else begin
          check("key1", out_key, sb1[0]);
          if (out_rdy) void'(sb1.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_err4) nerr4++;
      if (out_val4) begin
        if (sb4.size() == 0) check("val4_unexp", out_val4, 0);
        else begin
          check("key4", out_key4, sb4[0]);
          if (out_rdy4) void'(sb4.pop_front());
        end
      end
    end
  end

  initial begin
    out_rdy4 = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_rdy4 = rdy4_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic beat1(input logic [7:0] d, input logic last);
    int n = 0;
    in_val = 1'b1; in_dat = d; in_last = last;
    while (!in_rdy && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_rdy) check("rdy1_timeout", in_rdy, 1);
    @(posedge clk); #1;
    in_val = 1'b0; in_last = 1'b0;
  endtask

  task automatic frame1(input key_t kb, input logic [1:0] m,
                        input logic [255:0] exp);
    mode = m;
    sb1.push_back(exp);
    for (int i = 0; i < 32; i++) beat1(kb[i], i == 31);
  endtask

  task automatic beat4(input logic [31:0] d, input logic last);
    int n = 0;
    in_val4 = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_val4 = 1'b1; in_dat4 = d; in_last4 = last;
    while (!in_rdy4 && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_rdy4) check("rdy4_timeout", in_rdy4, 1);
    @(posedge clk); #1;
    in_val4 = 1'b0; in_last4 = 1'b0;
  endtask

  task automatic frame4(input key_t kb, input logic [1:0] m);
    mode4 = m;
    sb4.push_back(model(kb, m));
    for (int b = 0; b < 8; b++)
      beat4({kb[4*b+3], kb[4*b+2], kb[4*b+1], kb[4*b]}, b == 7);
  endtask

  task automatic drain(input int which);
    int n = 0;
    while (((which == 1) ? sb1.size() : sb4.size()) != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (which == 1) check("drain1", sb1.size(), 0);
    else check("drain4", sb4.size(), 0);
  endtask

  initial begin
    key_t kb;
    logic [255:0] rfc;
    int base;
    rst = 1'b1; mode = 2'd0; abort = 1'b0; in_val = 1'b0;
    in_dat = '0; in_last = 1'b0; out_rdy = 1'b1;
    mode4 = 2'd1; abort4 = 1'b0; in_val4 = 1'b0;
    in_dat4 = '0; in_last4 = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_key", out_key, 0);
    check("rst_val", out_val, 0);
    check("rst_err", out_err, 0);
    check("rst_rdy", in_rdy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_rst", in_rdy, 1);

    // RFC 7748 scalar, clamped, streamed a5 first
    rfc = 256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4;
    out_rdy = 1'b0; mode = 2'd1;
    sb1.push_back(256'h449a44ba44226a50185afcc10a4c1462dd5e46824b15163b9d7c52f06be346a0);
    for (int i = 0; i < 31; i++) beat1(rfc[255-8*i -: 8], 1'b0);
    check("val_early", out_val, 0);
    beat1(rfc[7:0], 1'b1);
    check("lat", out_val, 1);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    check("val_drop", out_val, 0);
    check("rdy_back", in_rdy, 1);

    for (int i = 0; i < 32; i++) kb[i] = 8'(i);
    frame1(kb, 2'd0,
      256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
    frame1(kb, 2'd2,
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    drain(1);

    base = nerr1;
    for (int i = 0; i <= 10; i++) beat1(8'(i), i == 10);
    @(posedge clk); #1;
    check("err_early", nerr1, base + 1);
    check("val_early_err", out_val, 0);
    for (int i = 0; i < 32; i++) beat1(8'(i), 1'b0);
    @(posedge clk); #1;
    check("err_missing", nerr1, base + 2);
    foreach (kb[i]) kb[i] = 8'($urandom);
    frame1(kb, 2'd0, model(kb, 2'd0));
    foreach (kb[i]) kb[i] = 8'($urandom);
    frame1(kb, 2'd3, model(kb, 2'd0));
    drain(1);

    out_rdy = 1'b0;
    foreach (kb[i]) kb[i] = 8'($urandom);
    frame1(kb, 2'd0, model(kb, 2'd0));
    in_val = 1'b1; in_dat = 8'hEE; in_last = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("rdy_stall", in_rdy, 0);
    end
    in_val = 1'b0; in_last = 1'b0; out_rdy = 1'b1;
    @(posedge clk); #1;
    check("rdy_resume", in_rdy, 1);
    foreach (kb[i]) kb[i] = 8'($urandom);
    frame1(kb, 2'd2, model(kb, 2'd2));
    drain(1);

    base = nerr1;
    mode = 2'd0;
    for (int i = 0; i < 15; i++) beat1(8'($urandom), 1'b0);
    in_val = 1'b1; in_dat = 8'h55; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_val = 1'b0;
    check("abort_rdy", in_rdy, 1);
    @(posedge clk); #1;
    check("abort_val", out_val, 0);
    check("abort_err", nerr1, base);
    foreach (kb[i]) kb[i] = 8'($urandom);
    mode = 2'd2;
    sb1.push_back(model(kb, 2'd2));
    beat1(kb[0], 1'b0);
    mode = 2'd1;
    for (int i = 1; i < 32; i++) beat1(kb[i], i == 31);
    drain(1);

    rdy4_rand = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      foreach (kb[i]) kb[i] = 8'($urandom);
      frame4(kb, 2'd1);
    end
    drain(4);
    check("err4_none", nerr4, 0);
    rdy4_rand = 1'b0;

    mode4 = 2'd1;
    for (int b = 0; b < 3; b++) beat4($urandom, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst4_key", out_key4, 0);
    check("rst4_val", out_val4, 0);
    check("rst4_err", out_err4, 0);
    check("rst4_rdy", in_rdy4, 0);
    check("rst1_key", out_key, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst4_rdy_back", in_rdy4, 1);
    foreach (kb[i]) kb[i] = 8'($urandom);
    frame4(kb, 2'd0);
    drain(4);
    check("sb1_left", sb1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
